// File: rtl/adc_to_qsm.sv
// Two-stage AXI-Stream pipeline that turns unsigned ADC samples into
// sign-magnitude Q-format words for the downstream adder.
module adc_to_qsm #(
  parameter int Q        = 15,
  parameter int N        = 32,
  parameter int ADC_BITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] offset,
  input  logic [15:0]         s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [N-1:0]        m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  localparam int DW = ADC_BITS + 1;
  localparam int SH = Q - ADC_BITS + 1;

  if (Q < ADC_BITS - 1) begin : g_bad_q
    $error("adc_to_qsm: Q must be at least ADC_BITS-1");
  end
  if (N - 1 < Q + 1) begin : g_bad_n
    $error("adc_to_qsm: N-1 must be at least Q+1");
  end
  if (ADC_BITS > 16 || ADC_BITS < 1) begin : g_bad_adc
    $error("adc_to_qsm: ADC_BITS must be within 1..16");
  end

  // Raw bits above the ADC resolution carry no information.
  if (ADC_BITS < 16) begin : g_ignore_hi
    logic unused_tdata_hi;
    assign unused_tdata_hi = ^s_axis_tdata[15:ADC_BITS];
  end

  logic            ready_en;
  logic            s1_valid;
  logic [DW-1:0]   s1_d;
  logic            s1_last;
  logic            out_adv;
  logic            accept;
  logic [ADC_BITS-1:0] abs_d;
  logic [N-2:0]    mag_c;
  logic            sign_c;

  assign out_adv       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = ready_en && (!s1_valid || out_adv);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // |d| never exceeds 2^ADC_BITS-1, so ADC_BITS magnitude bits suffice.
  always_comb begin
    abs_d  = s1_d[DW-1] ? ADC_BITS'(~s1_d + DW'(1)) : s1_d[ADC_BITS-1:0];
    mag_c  = '0;
    mag_c[ADC_BITS-1:0] = abs_d;
    mag_c  = mag_c << SH;
    sign_c = s1_d[DW-1] && (mag_c != '0);
  end

  // Holds s_axis_tready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_d     <= {1'b0, s_axis_tdata[ADC_BITS-1:0]} - {1'b0, offset};
      s1_last  <= s_axis_tlast;
    end else if (out_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_adv) begin
      m_axis_tvalid <= s1_valid;
      if (s1_valid) begin
        m_axis_tdata <= {sign_c, mag_c};
        m_axis_tlast <= s1_last;
      end
    end
  end

endmodule

// File: doc/adc_to_qsm.md
ADC_TO_QSM -- requirements
Module: adc_to_qsm

Interface
REQ-001 The block SHALL have parameter Q, default 15, meaning the number of fractional bits of the output word.
REQ-002 The block SHALL have parameter N, default 32, meaning the total output width (1 sign bit + N-1 magnitude bits).
REQ-003 The block SHALL have parameter ADC_BITS, default 12, meaning the number of valid raw ADC bits in s_axis_tdata[ADC_BITS-1:0].
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-006 The block SHALL have port offset, input, ADC_BITS, the unsigned mid-scale code subtracted from each sample.
REQ-007 The block SHALL have port s_axis_tdata, input, 16, the raw unsigned ADC sample; bits above ADC_BITS-1 are ignored.
REQ-008 The block SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1) and s_axis_tlast (input, 1), the AXI-Stream slave handshake.
REQ-009 The block SHALL have port m_axis_tdata, output, N, the sign-magnitude Q-format result.
REQ-010 The block SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), the AXI-Stream master handshake.

Function
REQ-011 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high on a rising clk edge; offset SHALL be sampled on that same edge and apply to that beat only.
REQ-012 Stage 1 SHALL register d = raw - offset as an (ADC_BITS+1)-bit two's-complement value, together with tlast.
REQ-013 Stage 2 SHALL register sign = d[MSB], mag = |d| shifted left by (Q - ADC_BITS + 1), zero-extended to N-1 bits, and tlast.
REQ-014 When mag is zero, sign SHALL be 0; negative zero SHALL never be output.
REQ-015 m_axis_tdata SHALL be {sign, mag}, which is the sign-magnitude operand format consumed by the downstream adder.
REQ-016 Elaboration SHALL fail if Q < ADC_BITS-1 or if N-1 < Q+1; no runtime saturation logic is required.
REQ-017 Latency from input acceptance to m_axis_tvalid high SHALL be exactly 2 cycles while m_axis_tready is high.
REQ-018 Throughput SHALL be one beat per cycle with no bubbles while m_axis_tready is continuously high.
REQ-019 Each stage SHALL load when it is empty or when its content is advancing on the same edge; s_axis_tready SHALL equal (!stage1_valid || stage1 advancing), and MAY depend combinationally on m_axis_tready.
REQ-020 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata, m_axis_tlast and m_axis_tvalid SHALL hold stable.
REQ-021 Beat order SHALL be preserved, and no beat SHALL be dropped or duplicated under any valid/ready pattern.
REQ-022 m_axis_tlast SHALL accompany the same beat on which s_axis_tlast was accepted.

Reset
REQ-023 While rst is high, stage valids, m_axis_tvalid, m_axis_tlast and s_axis_tready SHALL be 0, and m_axis_tdata SHALL be all zeros, asynchronously.
REQ-024 Assertion of rst mid-stream SHALL discard all in-flight beats; after deassertion s_axis_tready SHALL go high on the first clk edge.

Verification
REQ-025 With offset=2048, m_axis_tready=1, and inputs 2048, 4095, 0, 2047 sent back to back, outputs SHALL be 0x00000000, 0x00007FF0, 0x80008000, 0x80000010 on cycles 2, 3, 4, 5.
REQ-026 With offset=0 and input 0, the output SHALL be 0x00000000 (no negative zero); with offset=4095 and input 0, the output SHALL be 0x8000FFF0.
REQ-027 With a continuous input stream and m_axis_tready low for 5 cycles, s_axis_tready SHALL drop after 2 beats are buffered, output data SHALL hold stable, and all beats SHALL arrive in order once ready returns.
REQ-028 With random valid/ready toggling over 1000 beats checked against a scoreboard model, data and tlast SHALL match with no loss or duplication.
REQ-029 Asserting rst while 2 beats are in flight SHALL force m_axis_tvalid=0 immediately; after release, a new sample 2100 with offset=2048 SHALL yield 0x00000340 after 2 cycles.
REQ-030 Changing offset from 2048 to 1024 between two consecutive accepted beats of value 3072 SHALL yield 0x00004000 followed by 0x00008000.
